// File: rtl/param_sp_ram.sv
// rtl/param_sp_ram.sv - parameterised single-port RAM with byte enables, power-up clear engine and optional output stage
// io_data is shared: the bus master drives it for writes, the RAM drives it for reads when output-enabled.

module param_sp_ram #(
    parameter int   DATA_W  = 8,
    parameter int   ADDR_W  = 7,
    parameter int   OUT_REG = 0,
    localparam int  BE_W    = DATA_W / 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cs,
    input  logic                i_wr_e,
    input  logic                i_oe,
    input  logic [BE_W-1:0]     i_be,
    input  logic [ADDR_W-1:0]   i_address,
    inout  wire  [DATA_W-1:0]   io_data,
    output logic                o_busy,
    output logic                o_rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd_q;
    logic                rd_vld_q;
    logic [DATA_W-1:0]   out_data;
    logic                out_vld;

    logic                busy;
    logic                user_we;
    logic                rd_req;
    logic                drive_en;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The pointer parks on the last address rather than rolling over.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_CLEAR);
        user_we = !busy && i_cs && i_wr_e;
        rd_req  = !busy && i_cs && !i_wr_e;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (busy) begin
                mem_q[ptr_q] <= '0;
            end else if (user_we) begin
                for (int n = 0; n < BE_W; n++) begin
                    if (i_be[n]) begin
                        mem_q[i_address][8*n +: 8] <= io_data[8*n +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_req;
            if (rd_req) begin
                rd_q <= mem_q[i_address];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] pipe_q;
            logic              pipe_vld_q;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    pipe_q     <= '0;
                    pipe_vld_q <= 1'b0;
                end else begin
                    pipe_vld_q <= rd_vld_q;
                    if (rd_vld_q) begin
                        pipe_q <= rd_q;
                    end
                end
            end

            assign out_data = pipe_q;
            assign out_vld  = pipe_vld_q;
        end else begin : g_no_out_reg
            assign out_data = rd_q;
            assign out_vld  = rd_vld_q;
        end
    endgenerate

    // Bus drive ignores o_rd_valid; the master samples on the valid pulse.
    assign drive_en   = i_cs && i_oe && !i_wr_e && !busy;
    assign io_data    = drive_en ? out_data : {DATA_W{1'bz}};
    assign o_busy     = busy;
    assign o_rd_valid = out_vld;

endmodule
